cpri_rx_pack: RTL and testbench

Receive-side packer for the CPRI IQ path. It takes the 64-bit IQ word stream recovered from the CPRI link, frames it into 96-word packets, and writes each packet into the async loop buffer that feeds the TX generator. Payload words go to buffer addresses 3..98. A 3-word header (addresses 0..2) is written last and commits the packet. It is the writer counterpart of the TX packet reader, which skips header words 0..2 and streams addresses 3..98.

---
 rtl/cpri_rx_pack.sv | 174 +++++++++++++++++
 tb/tb_cpri_rx_pack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpri_rx_pack.sv
// cpri_rx_pack
// Receive-side packer for the CPRI IQ path. Frames the recovered 64-bit IQ
// word stream into fixed-length packets and writes them into the loop buffer.
// Payload words land at addresses HDR_LEN..HDR_LEN+PKT_LEN-1. The header
// (addresses 0..HDR_LEN-1) is written after the payload, and the last header
// write carries o_cpri_wlast, which commits the slot.
//
// Ports
//   wr_clk, wr_rst        : clock, synchronous active-high reset
//   i_rx_enable           : packet acceptance enable (checked at sop only)
//   i_iq_rx_valid/sop/data: input IQ word stream
//   i_free_size           : free packet slots in the loop buffer
//   o_cpri_wen/waddr/wdata: registered buffer write port
//   o_cpri_wlast          : last write of a packet (commit)
//   o_pkt_cnt, o_drop_cnt : committed / dropped-or-aborted packet counters
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for an accepted sop
// S_PAYLOAD| writing payload words at HDR_LEN+idx
// S_HDR0   | writing header word 0 {seq, length}
// S_HDR1   | writing header word 1 {timestamp}
// S_HDR2   | writing header word 2 {drop count}, commit

module cpri_rx_pack #(
    parameter int PKT_LEN    = 96,
    parameter int HDR_LEN    = 3,
    parameter int FREE_WIDTH = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  i_rx_enable,
    input  logic                  i_iq_rx_valid,
    input  logic                  i_iq_rx_sop,
    input  logic [63:0]           i_iq_rx_data,
    input  logic [FREE_WIDTH-1:0] i_free_size,
    output logic                  o_cpri_wen,
    output logic [6:0]            o_cpri_waddr,
    output logic [63:0]           o_cpri_wdata,
    output logic                  o_cpri_wlast,
    output logic [15:0]           o_pkt_cnt,
    output logic [15:0]           o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_HDR0,
        S_HDR1,
        S_HDR2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  idx, idx_nxt;
    logic [31:0] ts_cnt;
    logic [31:0] ts_cap;
    logic [15:0] drop_cap;

    logic        wen_nxt;
    logic [6:0]  waddr_nxt;
    logic [63:0] wdata_nxt;
    logic        wlast_nxt;
    logic        pkt_inc;
    logic [1:0]  drop_add;
    logic        start;
    logic        sop_word;
    logic [15:0] drop_cnt_nxt;

    assign sop_word     = i_iq_rx_valid & i_iq_rx_sop;
    assign drop_cnt_nxt = o_drop_cnt + 16'(drop_add);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wen_nxt   = 1'b0;
        waddr_nxt = o_cpri_waddr;
        wdata_nxt = o_cpri_wdata;
        wlast_nxt = 1'b0;
        pkt_inc   = 1'b0;
        drop_add  = 2'd0;
        start     = 1'b0;

        case (state)
            S_IDLE: begin
                if (sop_word && i_rx_enable) begin
                    if (i_free_size != '0) start = 1'b1;
                    else                   drop_add = 2'd1;
                end
            end
            S_PAYLOAD: begin
                if (sop_word) begin
                    // Abort counts once; a rejected restart counts again.
                    if (i_rx_enable && (i_free_size != '0)) begin
                        drop_add = 2'd1;
                        start    = 1'b1;
                    end else begin
                        drop_add  = 2'd2;
                        state_nxt = S_IDLE;
                    end
                end else if (i_iq_rx_valid) begin
                    wen_nxt   = 1'b1;
                    waddr_nxt = 7'(HDR_LEN) + idx;
                    wdata_nxt = i_iq_rx_data;
                    idx_nxt   = idx + 7'd1;
                    if (idx == 7'(PKT_LEN - 1)) state_nxt = S_HDR0;
                end
            end
            S_HDR0: begin
                wen_nxt   = 1'b1;
                waddr_nxt = 7'd0;
                wdata_nxt = {32'd0, o_pkt_cnt, 16'(PKT_LEN)};
                state_nxt = S_HDR1;
                if (sop_word) drop_add = 2'd1;
            end
            S_HDR1: begin
                wen_nxt   = 1'b1;
                waddr_nxt = 7'd1;
                wdata_nxt = {32'd0, ts_cap};
                state_nxt = S_HDR2;
                if (sop_word) drop_add = 2'd1;
            end
            S_HDR2: begin
                wen_nxt   = 1'b1;
                waddr_nxt = 7'd2;
                wdata_nxt = {48'd0, drop_cap};
                wlast_nxt = 1'b1;
                pkt_inc   = 1'b1;
                state_nxt = S_IDLE;
                if (sop_word) drop_add = 2'd1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (start) begin
            wen_nxt   = 1'b1;
            waddr_nxt = 7'(HDR_LEN);
            wdata_nxt = i_iq_rx_data;
            idx_nxt   = 7'd1;
            state_nxt = S_PAYLOAD;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            ts_cnt       <= '0;
            ts_cap       <= '0;
            drop_cap     <= '0;
            o_cpri_wen   <= 1'b0;
            o_cpri_waddr <= '0;
            o_cpri_wdata <= '0;
            o_cpri_wlast <= 1'b0;
            o_pkt_cnt    <= '0;
            o_drop_cnt   <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            ts_cnt       <= ts_cnt + 32'd1;
            o_cpri_wen   <= wen_nxt;
            o_cpri_waddr <= waddr_nxt;
            o_cpri_wdata <= wdata_nxt;
            o_cpri_wlast <= wlast_nxt;
            o_pkt_cnt    <= o_pkt_cnt + 16'(pkt_inc);
            o_drop_cnt   <= drop_cnt_nxt;
            if (start) begin
                ts_cap   <= ts_cnt;
                // Includes an abort counted in this same cycle.
                drop_cap <= drop_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cpri_rx_pack.sv
module tb_cpri_rx_pack;

    logic        wr_clk = 1'b0;
    logic        wr_rst = 1'b1;
    logic        i_rx_enable = 1'b1;
    logic        i_iq_rx_valid = 1'b0;
    logic        i_iq_rx_sop = 1'b0;
    logic [63:0] i_iq_rx_data = '0;
    logic [3:0]  i_free_size = 4'd4;
    logic        o_cpri_wen;
    logic [6:0]  o_cpri_waddr;
    logic [63:0] o_cpri_wdata;
    logic        o_cpri_wlast;
    logic [15:0] o_pkt_cnt;
    logic [15:0] o_drop_cnt;

    cpri_rx_pack dut (
        .wr_clk        (wr_clk),
        .wr_rst        (wr_rst),
        .i_rx_enable   (i_rx_enable),
        .i_iq_rx_valid (i_iq_rx_valid),
        .i_iq_rx_sop   (i_iq_rx_sop),
        .i_iq_rx_data  (i_iq_rx_data),
        .i_free_size   (i_free_size),
        .o_cpri_wen    (o_cpri_wen),
        .o_cpri_waddr  (o_cpri_waddr),
        .o_cpri_wdata  (o_cpri_wdata),
        .o_cpri_wlast  (o_cpri_wlast),
        .o_pkt_cnt     (o_pkt_cnt),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [6:0]  addr;
        logic [63:0] data;
        logic        last;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] tb_ts = '0;

    // Reference timestamp: free-running from reset, as seen at the next edge.
    always @(posedge wr_clk) tb_ts <= wr_rst ? 32'd0 : tb_ts + 32'd1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    always @(negedge wr_clk) begin
        if (o_cpri_wen) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write_addr", {57'd0, o_cpri_waddr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("waddr", {57'd0, o_cpri_waddr}, {57'd0, e.addr});
                check_val("wdata", o_cpri_wdata, e.data);
                check_val("wlast", {63'd0, o_cpri_wlast}, {63'd0, e.last});
            end
        end else begin
            check_val("wlast_without_wen", {63'd0, o_cpri_wlast}, 64'd0);
        end
    end

    task automatic push_wr(input int addr, input logic [63:0] data, input logic last);
        wr_t e;
        e.addr = 7'(addr);
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_hdr(input logic [15:0] seq, input logic [31:0] ts, input logic [15:0] drop);
        push_wr(0, {32'd0, seq, 16'd96}, 1'b0);
        push_wr(1, {32'd0, ts}, 1'b0);
        push_wr(2, {48'd0, drop}, 1'b1);
    endtask

    task automatic idle(input int n);
        i_iq_rx_valid = 1'b0;
        i_iq_rx_sop   = 1'b0;
        repeat (n) @(negedge wr_clk);
    endtask

    task automatic do_reset();
        wr_rst        = 1'b1;
        i_rx_enable   = 1'b1;
        i_free_size   = 4'd4;
        i_iq_rx_valid = 1'b0;
        i_iq_rx_sop   = 1'b0;
        repeat (2) @(negedge wr_clk);
        wr_rst = 1'b0;
    endtask

    // Sends n payload words (sop on the first), expecting each to be written.
    task automatic send_payload(input int n, input bit gaps, input bit en_drop,
                                input logic [63:0] base, output logic [31:0] ts);
        ts = tb_ts;
        for (int k = 0; k < n; k++) begin
            i_iq_rx_valid = 1'b1;
            i_iq_rx_sop   = (k == 0);
            i_iq_rx_data  = base + 64'(k);
            push_wr(3 + k, base + 64'(k), 1'b0);
            @(negedge wr_clk);
            if (gaps) begin
                i_iq_rx_valid = 1'b0;
                i_iq_rx_sop   = 1'b0;
                i_iq_rx_data  = 64'hDEAD_BEEF_0000_0000;
                if (en_drop && k == 48) i_rx_enable = 1'b0;
                @(negedge wr_clk);
            end
        end
        i_iq_rx_valid = 1'b0;
        i_iq_rx_sop   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ts0, ts1;
        @(negedge wr_clk);
        do_reset();
        check_val("reset_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd0);
        check_val("reset_drop_cnt", {48'd0, o_drop_cnt}, 64'd0);
        check_val("reset_wen", {63'd0, o_cpri_wen}, 64'd0);

        // Back-to-back packets, next sop 4 cycles after the last word.
        send_payload(96, 1'b0, 1'b0, 64'd0, ts0);
        push_hdr(16'd0, ts0, 16'd0);
        idle(3);
        send_payload(96, 1'b0, 1'b0, 64'd1000, ts1);
        push_hdr(16'd1, ts1, 16'd0);
        idle(6);
        check_val("b2b_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd2);
        check_val("b2b_drop_cnt", {48'd0, o_drop_cnt}, 64'd0);

        // Header collision: sop at t+2 rejected, trailing non-sop words ignored.
        do_reset();
        send_payload(96, 1'b0, 1'b0, 64'd200, ts0);
        push_hdr(16'd0, ts0, 16'd0);
        idle(1);
        i_iq_rx_valid = 1'b1;
        i_iq_rx_sop   = 1'b1;
        i_iq_rx_data  = 64'h5555;
        @(negedge wr_clk);
        i_iq_rx_sop = 1'b0;
        repeat (3) @(negedge wr_clk);
        idle(4);
        check_val("collision_drop_cnt", {48'd0, o_drop_cnt}, 64'd1);
        check_val("collision_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd1);

        // Truncation after 50 words; the new sop restarts at address 3.
        do_reset();
        send_payload(50, 1'b0, 1'b0, 64'h7000, ts0);
        send_payload(96, 1'b0, 1'b0, 64'h9000, ts1);
        push_hdr(16'd0, ts1, 16'd1);
        idle(6);
        check_val("trunc_drop_cnt", {48'd0, o_drop_cnt}, 64'd1);
        check_val("trunc_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd1);

        // Full buffer at sop, then one free slot.
        do_reset();
        i_free_size   = 4'd0;
        i_iq_rx_valid = 1'b1;
        i_iq_rx_sop   = 1'b1;
        i_iq_rx_data  = 64'h1111;
        @(negedge wr_clk);
        i_iq_rx_sop = 1'b0;
        repeat (3) @(negedge wr_clk);
        idle(2);
        check_val("full_drop_cnt", {48'd0, o_drop_cnt}, 64'd1);
        i_free_size = 4'd1;
        send_payload(96, 1'b0, 1'b0, 64'hA000, ts0);
        push_hdr(16'd0, ts0, 16'd1);
        idle(6);
        check_val("full_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd1);

        // Gaps in valid with enable dropped mid-packet.
        do_reset();
        send_payload(96, 1'b1, 1'b1, 64'hB000, ts0);
        push_hdr(16'd0, ts0, 16'd0);
        idle(6);
        check_val("gaps_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd1);
        i_rx_enable   = 1'b0;
        i_iq_rx_valid = 1'b1;
        i_iq_rx_sop   = 1'b1;
        @(negedge wr_clk);
        idle(4);
        check_val("en_low_drop_cnt", {48'd0, o_drop_cnt}, 64'd0);
        i_rx_enable = 1'b1;

        // Reset at payload index 40.
        do_reset();
        send_payload(40, 1'b0, 1'b0, 64'hC000, ts0);
        i_iq_rx_valid = 1'b1;
        i_iq_rx_data  = 64'hC000 + 64'd40;
        wr_rst        = 1'b1;
        @(negedge wr_clk);
        check_val("rst_wen", {63'd0, o_cpri_wen}, 64'd0);
        check_val("rst_waddr", {57'd0, o_cpri_waddr}, 64'd0);
        check_val("rst_wdata", o_cpri_wdata, 64'd0);
        check_val("rst_wlast", {63'd0, o_cpri_wlast}, 64'd0);
        check_val("rst_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd0);
        check_val("rst_drop_cnt", {48'd0, o_drop_cnt}, 64'd0);
        wr_rst        = 1'b0;
        i_iq_rx_valid = 1'b0;
        idle(2);
        send_payload(96, 1'b0, 1'b0, 64'hD000, ts0);
        push_hdr(16'd0, ts0, 16'd0);
        idle(6);
        check_val("post_rst_pkt_cnt", {48'd0, o_pkt_cnt}, 64'd1);

        check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
